relm_op_loader: RTL and testbench
=================================

// Module: relm_op_loader
// PURPOSE
//  Byte-stream boot/patch loader for the ReLM op (code) memories. Parses framed
//  bytes from a host link (UART/FIFO side) and drives the relm op_we_in/op_wa_in/
//  op_d_in write port. Loading runs while the PE ring executes: no stall, no halt.
//  Address LSBs (WID) select the PE, so consecutive opcodes land round-robin.
// PARAMETERS
//  WID   0   log2 PE count; must match relm WID
//  WAD   0   op memory address width per PE; must match relm WAD
//  WOP   5   opcode width; must match relm WOP
//  WTO   16  timeout counter width; mid-frame abort after 2**WTO-1 idle cycles
// PORTS
//  clk          in   1        single clock, all logic on posedge
//  rst_n_in     in   1        reset, asynchronous, active-low
//  rx_d_in      in   8        stream byte
//  rx_valid_in  in   1        byte present
//  rx_ready_out out  1        loader accepts; byte taken when valid&ready
//  op_we_out    out  1        to relm op_we_in
//  op_wa_out    out  WAD+WID  to relm op_wa_in
//  op_d_out     out  WOP      to relm op_d_in
//  busy_out     out  1        frame in progress (state != IDLE)
//  done_out     out  1        1-cycle pulse: frame ended with good checksum
//  err_out      out  1        sticky error; cleared when next MAGIC accepted
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, all outputs 0, counters 0.
//   rx_ready_out=1 in every cycle out of reset; loader never backpressures.
//  Frame: MAGIC(0xA5) ADR_L ADR_H CNT_L CNT_H OP[0..CNT-1] SUM. 16-bit LE fields.
//  FSM: IDLE -MAGIC-> ADR0 -> ADR1 -> CNT0 -> CNT1 -> (CNT==0 ? SUM : DATA);
//   DATA stays until CNT opcodes taken -> SUM -> IDLE. Each arrow = 1 accepted byte.
//   IDLE ignores non-MAGIC bytes. MAGIC inside a frame is ordinary data.
//  Address: low WAD+WID bits of ADR kept, upper ignored; increments per opcode
//   byte, wraps modulo 2**(WAD+WID). Count is a full 16-bit down-counter.
//  Write: opcode byte accepted in cycle k -> op_we_out=1, op_wa_out=current addr,
//   op_d_out=byte[WOP-1:0] registered in cycle k+1. Max 1 write/cycle; back-to-back ok.
//   op_we_out=0 otherwise; op_wa_out/op_d_out hold last value.
//  Opcode byte with bits [7:WOP] nonzero: write suppressed, err_out=1, address
//   still increments, frame continues.
//  Checksum: 8-bit sum of ADR_L..last OP plus SUM must be 0x00. Good -> done_out
//   pulse in cycle after SUM accepted (and err_out unchanged). Bad -> err_out=1,
//   no done. Writes already issued are NOT rolled back.
//  Timeout: counter cleared on each accepted byte and in IDLE; counts otherwise.
//   Reaching all-ones -> IDLE, err_out=1, no done, no further writes.
//  err_out cleared in the cycle a MAGIC is accepted in IDLE.
//  Reset mid-frame: immediate IDLE; a write registered that cycle is dropped.
// STRUCTURE
//  Shared header relm_defs.vh: RELM_LOADER_MAGIC (8'hA5), FSM state encodings
//   (3-bit localparams L_IDLE..L_SUM); reused by host-side tooling model.
//  One sub-module: relm_loader_timeout (WTO-bit counter, clear/enable, expire out).
//  Datapath (addr, count, sum regs) and FSM live in relm_op_loader. ~200 lines.
// TESTING (WID=2, WAD=8, WOP=5, WTO=4 unless noted)
//  Basic: A5 10 00 03 00 01 02 03 E7 back-to-back -> writes (0x010,1),(0x011,2),
//   (0x012,3) in consecutive cycles, 1 cycle after each byte; done pulse; err=0.
//  Wrap+zero count: A5 FF 03 02 00 07 08 ED -> writes 0x3FF,0x000; then
//   A5 20 00 00 00 E0 -> no writes, done pulse.
//  Bad checksum: basic frame with SUM=E8 -> 3 writes occur, no done, err=1;
//   next A5 clears err in the cycle it is accepted.
//  Illegal opcode: A5 00 00 02 00 20 01 DD -> no write at 0x000, write (0x001,1),
//   err=1, no done (sum valid: 0x23+0xDD=0x00).
//  Timeout: A5 10 00 then 15 cycles valid=0 -> busy drops, err=1; later stray
//   bytes ignored until A5; following good frame loads normally.
//  Reset: assert rst_n_in=0 between OP bytes, async (mid-cycle) -> outputs 0
//   immediately; after release IDLE, ready=1, no spurious write.

Source files
------------

// File: rtl/relm_op_loader_pkg.sv
// Shared loader constants: frame magic byte and FSM state encoding.
package relm_op_loader_pkg;

  localparam logic [7:0] RELM_LOADER_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_ADR0 = 3'd1,
    L_ADR1 = 3'd2,
    L_CNT0 = 3'd3,
    L_CNT1 = 3'd4,
    L_DATA = 3'd5,
    L_SUM  = 3'd6
  } loader_state_e;

endpackage

// File: rtl/relm_op_loader_timeout.sv
// Idle-cycle watchdog for the op loader: counts while enabled and not cleared,
// flags expiry on the cycle the counter is about to reach all-ones.
module relm_loader_timeout #(
  parameter int WTO = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [WTO-1:0] ONES = '1;
  localparam logic [WTO-1:0] LAST = ONES - 1'b1;

  logic [WTO-1:0] r_cnt;

  // Idle counter: reset by activity or by the loader being idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || !i_en) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry coincides with the edge at which the count reaches all-ones.
  assign o_expire = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/relm_op_loader.sv
// Byte-stream boot/patch loader for the ReLM op memories. Parses
// MAGIC ADR_L ADR_H CNT_L CNT_H OP[0..CNT-1] SUM frames and drives the
// op memory write port while the PE ring keeps running.
module relm_op_loader
  import relm_op_loader_pkg::*;
#(
  parameter int WID = 0,
  parameter int WAD = 0,
  parameter int WOP = 5,
  parameter int WTO = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n_in,
  input  logic [7:0]                                  rx_d_in,
  input  logic                                        rx_valid_in,
  output logic                                        rx_ready_out,
  output logic                                        op_we_out,
  output logic [((WAD+WID) > 0 ? (WAD+WID) : 1)-1:0]  op_wa_out,
  output logic [WOP-1:0]                              op_d_out,
  output logic                                        busy_out,
  output logic                                        done_out,
  output logic                                        err_out
);

  // A zero-width address (single PE, single op) degenerates to one bit.
  localparam int WA = (WAD + WID) > 0 ? (WAD + WID) : 1;

  loader_state_e   r_state;
  logic            r_ready;
  logic            r_we;
  logic [WA-1:0]   r_wa;
  logic [WOP-1:0]  r_d;
  logic            r_done;
  logic            r_err;
  logic [15:0]     r_addr;
  logic [15:0]     r_cnt;
  logic [7:0]      r_sum;

  logic            w_accept;
  logic            w_op_bad;
  logic            w_expire;
  logic            w_busy;

  assign w_accept = rx_valid_in && r_ready;
  assign w_op_bad = (rx_d_in >> WOP) != 8'd0;
  assign w_busy   = (r_state != L_IDLE);

  relm_loader_timeout #(
    .WTO (WTO)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n_in),
    .i_clr    (w_accept),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  // Frame parser FSM with datapath (address, count, checksum) and registered outputs.
  // The full 16-bit address is kept; only its low WA bits are emitted, which
  // wraps identically to a WA-bit counter.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= L_IDLE;
      r_ready <= 1'b0;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_d     <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      r_ready <= 1'b1;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      if (w_expire) begin
        r_state <= L_IDLE;
        r_err   <= 1'b1;
      end else if (w_accept) begin
        if (r_state != L_IDLE) begin
          r_sum <= r_sum + rx_d_in;
        end
        case (r_state)
          L_IDLE: begin
            if (rx_d_in == RELM_LOADER_MAGIC) begin
              r_state <= L_ADR0;
              r_err   <= 1'b0;
              r_sum   <= '0;
            end
          end
          L_ADR0: begin
            r_addr[7:0] <= rx_d_in;
            r_state     <= L_ADR1;
          end
          L_ADR1: begin
            r_addr[15:8] <= rx_d_in;
            r_state      <= L_CNT0;
          end
          L_CNT0: begin
            r_cnt[7:0] <= rx_d_in;
            r_state    <= L_CNT1;
          end
          L_CNT1: begin
            r_cnt[15:8] <= rx_d_in;
            r_state     <= ({rx_d_in, r_cnt[7:0]} == 16'd0) ? L_SUM : L_DATA;
          end
          L_DATA: begin
            r_addr <= r_addr + 16'd1;
            r_cnt  <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              r_state <= L_SUM;
            end
            if (w_op_bad) begin
              r_err <= 1'b1;
            end else begin
              r_we <= 1'b1;
              r_wa <= r_addr[WA-1:0];
              r_d  <= rx_d_in[WOP-1:0];
            end
          end
          L_SUM: begin
            r_state <= L_IDLE;
            if ((r_sum + rx_d_in) == 8'd0) begin
              if (!r_err) begin
                r_done <= 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
          default: r_state <= L_IDLE;
        endcase
      end
    end
  end

  assign rx_ready_out = r_ready;
  assign op_we_out    = r_we;
  assign op_wa_out    = r_wa;
  assign op_d_out     = r_d;
  assign busy_out     = w_busy;
  assign done_out     = r_done;
  assign err_out      = r_err;

endmodule

// File: tb/tb_relm_op_loader.sv
// Directed-vector bench for relm_op_loader (WID=2, WAD=8, WOP=5, WTO=4).
module tb_relm_op_loader;

  logic        clk;
  logic        rst_n_in;
  logic [7:0]  rx_d_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic        op_we_out;
  logic [9:0]  op_wa_out;
  logic [4:0]  op_d_out;
  logic        busy_out;
  logic        done_out;
  logic        err_out;

  int vectors;
  int errs;

  relm_op_loader #(
    .WID (2),
    .WAD (8),
    .WOP (5),
    .WTO (4)
  ) dut (
    .clk          (clk),
    .rst_n_in     (rst_n_in),
    .rx_d_in      (rx_d_in),
    .rx_valid_in  (rx_valid_in),
    .rx_ready_out (rx_ready_out),
    .op_we_out    (op_we_out),
    .op_wa_out    (op_wa_out),
    .op_d_out     (op_d_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one accepted cycle; returns 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    rx_d_in     = b;
    rx_valid_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_wr(input string tag, input logic [9:0] wa, input logic [4:0] d);
    chk({tag, ".we"}, {31'd0, op_we_out}, 32'd1);
    chk({tag, ".wa"}, {22'd0, op_wa_out}, {22'd0, wa});
    chk({tag, ".d"},  {27'd0, op_d_out},  {27'd0, d});
  endtask

  task automatic chk_nowr(input string tag);
    chk({tag, ".we"}, {31'd0, op_we_out}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    errs        = 0;
    rst_n_in    = 1'b0;
    rx_d_in     = 8'h00;
    rx_valid_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", {31'd0, rx_ready_out}, 32'd0);
    chk("rst.we",    {31'd0, op_we_out},    32'd0);
    chk("rst.wa",    {22'd0, op_wa_out},    32'd0);
    chk("rst.d",     {27'd0, op_d_out},     32'd0);
    chk("rst.busy",  {31'd0, busy_out},     32'd0);
    chk("rst.done",  {31'd0, done_out},     32'd0);
    chk("rst.err",   {31'd0, err_out},      32'd0);
    @(negedge clk);
    rst_n_in = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.ready", {31'd0, rx_ready_out}, 32'd1);
    chk("rel.busy",  {31'd0, busy_out},     32'd0);

    // Basic frame: A5 10 00 03 00 01 02 03 E7
    send(8'hA5);
    chk("b.busy", {31'd0, busy_out}, 32'd1);
    send(8'h10); send(8'h00); send(8'h03); send(8'h00);
    chk_nowr("b.hdr");
    send(8'h01); chk_wr("b.op0", 10'h010, 5'd1);
    send(8'h02); chk_wr("b.op1", 10'h011, 5'd2);
    send(8'h03); chk_wr("b.op2", 10'h012, 5'd3);
    send(8'hE7);
    chk_nowr("b.sum");
    chk("b.done", {31'd0, done_out}, 32'd1);
    chk("b.err",  {31'd0, err_out},  32'd0);
    chk("b.busy_end", {31'd0, busy_out}, 32'd0);
    idle(1);
    chk("b.done_pulse", {31'd0, done_out}, 32'd0);
    chk("b.hold_wa", {22'd0, op_wa_out}, 32'h012);

    // Address wrap: A5 FF 03 02 00 07 08 ED
    send(8'hA5); send(8'hFF); send(8'h03); send(8'h02); send(8'h00);
    send(8'h07); chk_wr("w.op0", 10'h3FF, 5'd7);
    send(8'h08); chk_wr("w.op1", 10'h000, 5'd8);
    send(8'hED);
    chk("w.done", {31'd0, done_out}, 32'd1);
    chk("w.err",  {31'd0, err_out},  32'd0);

    // Zero count: A5 20 00 00 00 E0
    send(8'hA5); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
    chk_nowr("z.cnt");
    chk("z.busy", {31'd0, busy_out}, 32'd1);
    send(8'hE0);
    chk_nowr("z.sum");
    chk("z.done", {31'd0, done_out}, 32'd1);
    chk("z.busy_end", {31'd0, busy_out}, 32'd0);

    // Bad checksum: basic frame with SUM=E8
    send(8'hA5); send(8'h10); send(8'h00); send(8'h03); send(8'h00);
    send(8'h01); chk_wr("c.op0", 10'h010, 5'd1);
    send(8'h02); chk_wr("c.op1", 10'h011, 5'd2);
    send(8'h03); chk_wr("c.op2", 10'h012, 5'd3);
    send(8'hE8);
    chk("c.done", {31'd0, done_out}, 32'd0);
    chk("c.err",  {31'd0, err_out},  32'd1);

    // Illegal opcode: A5 00 00 02 00 20 01 DD (MAGIC also clears err)
    send(8'hA5);
    chk("i.err_clr", {31'd0, err_out}, 32'd0);
    send(8'h00); send(8'h00); send(8'h02); send(8'h00);
    send(8'h20);
    chk_nowr("i.op0");
    chk("i.err_set", {31'd0, err_out}, 32'd1);
    send(8'h01); chk_wr("i.op1", 10'h001, 5'd1);
    send(8'hDD);
    chk("i.done", {31'd0, done_out}, 32'd0);
    chk("i.err",  {31'd0, err_out},  32'd1);
    chk("i.busy", {31'd0, busy_out}, 32'd0);

    // Timeout: A5 10 00 then 15 idle cycles
    send(8'hA5);
    chk("t.err_clr", {31'd0, err_out}, 32'd0);
    send(8'h10); send(8'h00);
    idle(14);
    chk("t.busy14", {31'd0, busy_out}, 32'd1);
    idle(1);
    chk("t.busy15", {31'd0, busy_out}, 32'd0);
    chk("t.err",    {31'd0, err_out},  32'd1);
    chk("t.done",   {31'd0, done_out}, 32'd0);
    send(8'h10); send(8'h00); send(8'h03); send(8'h00); send(8'h01);
    chk_nowr("t.stray");
    chk("t.stray_busy", {31'd0, busy_out}, 32'd0);
    chk("t.stray_err",  {31'd0, err_out},  32'd1);
    send(8'hA5); send(8'h10); send(8'h00); send(8'h03); send(8'h00);
    send(8'h01); chk_wr("t.op0", 10'h010, 5'd1);
    send(8'h02); chk_wr("t.op1", 10'h011, 5'd2);
    send(8'h03); chk_wr("t.op2", 10'h012, 5'd3);
    send(8'hE7);
    chk("t.done_ok", {31'd0, done_out}, 32'd1);
    chk("t.err_ok",  {31'd0, err_out},  32'd0);

    // Asynchronous reset between opcode bytes
    send(8'hA5); send(8'h10); send(8'h00); send(8'h03); send(8'h00);
    send(8'h01);
    send(8'h02); chk_wr("r.pre", 10'h011, 5'd2);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("r.we",    {31'd0, op_we_out},    32'd0);
    chk("r.wa",    {22'd0, op_wa_out},    32'd0);
    chk("r.d",     {27'd0, op_d_out},     32'd0);
    chk("r.busy",  {31'd0, busy_out},     32'd0);
    chk("r.ready", {31'd0, rx_ready_out}, 32'd0);
    rx_valid_in = 1'b0;
    @(negedge clk);
    rst_n_in = 1'b1;
    @(posedge clk);
    #1;
    chk("r.ready_rel", {31'd0, rx_ready_out}, 32'd1);
    chk("r.busy_rel",  {31'd0, busy_out},     32'd0);
    chk_nowr("r.rel");
    send(8'h03);
    chk_nowr("r.stray");
    chk("r.stray_busy", {31'd0, busy_out}, 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
